// File: rtl/ssd_pkg.sv
// Shared glyph constants and BCD-to-segment helper for the seven-segment scan driver.
// Segments are active-low and ordered {a,b,c,d,e,f,g,dp}.
package ssd_pkg;

    localparam int unsigned SEG_A_BIT  = 7;
    localparam int unsigned SEG_B_BIT  = 6;
    localparam int unsigned SEG_C_BIT  = 5;
    localparam int unsigned SEG_D_BIT  = 4;
    localparam int unsigned SEG_E_BIT  = 3;
    localparam int unsigned SEG_F_BIT  = 2;
    localparam int unsigned SEG_G_BIT  = 1;
    localparam int unsigned SEG_DP_BIT = 0;

    localparam logic [7:0] SEG_0     = 8'b0000_0011;
    localparam logic [7:0] SEG_1     = 8'b1001_1111;
    localparam logic [7:0] SEG_2     = 8'b0010_0101;
    localparam logic [7:0] SEG_3     = 8'b0000_1101;
    localparam logic [7:0] SEG_4     = 8'b1001_1001;
    localparam logic [7:0] SEG_5     = 8'b0100_1001;
    localparam logic [7:0] SEG_6     = 8'b0100_0001;
    localparam logic [7:0] SEG_7     = 8'b0001_1111;
    localparam logic [7:0] SEG_8     = 8'b0000_0001;
    localparam logic [7:0] SEG_9     = 8'b0000_1001;
    localparam logic [7:0] SEG_DASH  = 8'b1111_1101;
    localparam logic [7:0] SEG_BLANK = 8'b1111_1111;

    localparam logic [1:0] IDX_RESET = 2'd3;

    // Returns segments a..g only; the caller supplies dp.
    function automatic logic [6:0] bcd_to_seg(input logic [3:0] code);
        logic [7:0] glyph;
        glyph = SEG_DASH;
        case (code)
            4'd0: glyph = SEG_0;
            4'd1: glyph = SEG_1;
            4'd2: glyph = SEG_2;
            4'd3: glyph = SEG_3;
            4'd4: glyph = SEG_4;
            4'd5: glyph = SEG_5;
            4'd6: glyph = SEG_6;
            4'd7: glyph = SEG_7;
            4'd8: glyph = SEG_8;
            4'd9: glyph = SEG_9;
            default: glyph = SEG_DASH;
        endcase
        return glyph[SEG_A_BIT:SEG_G_BIT];
    endfunction

endpackage

// File: rtl/ssd_decoder.sv
// Combinational BCD digit to active-low a..g segment decoder; codes 10-15 show a dash.
module ssd_decoder
    import ssd_pkg::*;
(
    input  logic [3:0] code_i,
    output logic [6:0] seg_o
);

    always_comb begin
        seg_o = bcd_to_seg(code_i);
    end

endmodule

// File: rtl/ssd_scan_driver.sv
// Four-digit common-anode scan driver with frame-boundary double buffering.
// Optional leading-zero blanking on d3..d1 is enabled by defining SSD_LEADING_ZERO_BLANK_EN.
module ssd_scan_driver
    import ssd_pkg::*;
#(
    parameter int unsigned REFRESH_DIV = 100000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] d3,
    input  logic [3:0] d2,
    input  logic [3:0] d1,
    input  logic [3:0] d0,
    input  logic       load,
    input  logic [3:0] dp_mask,
    output logic [3:0] ssd_ctl,
    output logic [7:0] ssd_seg,
    output logic       frame_done
);

    localparam int unsigned CntW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CntW-1:0] DivMax = CntW'(REFRESH_DIV - 1);

    logic [CntW-1:0]      div_cnt_q, div_cnt_d;
    logic [1:0]           idx_q, idx_d;
    logic [3:0][3:0]      pend_dig_q, pend_dig_d;
    logic [3:0]           pend_dp_q, pend_dp_d;
    logic                 pend_valid_q, pend_valid_d;
    logic [3:0][3:0]      disp_dig_q, disp_dig_d;
    logic [3:0]           disp_dp_q, disp_dp_d;
    logic [3:0]           ctl_q, ctl_d;
    logic [7:0]           seg_q, seg_d;

    logic                 tick;
    logic                 boundary;
    logic [3:0][3:0]      load_dig;
    logic [3:0]           sel_code;
    logic [6:0]           dec_seg;
    logic [3:0]           blank;

    assign load_dig = {d3, d2, d1, d0};

    always_comb begin
        tick      = (div_cnt_q == DivMax);
        boundary  = tick && (idx_q == 2'd3);
        div_cnt_d = tick ? '0 : div_cnt_q + CntW'(1);
        idx_d     = tick ? idx_q + 2'd1 : idx_q;

        pend_dig_d   = pend_dig_q;
        pend_dp_d    = pend_dp_q;
        pend_valid_d = pend_valid_q;
        disp_dig_d   = disp_dig_q;
        disp_dp_d    = disp_dp_q;

        // A load landing on the boundary skips the pending buffer entirely.
        if (boundary && load) begin
            disp_dig_d   = load_dig;
            disp_dp_d    = dp_mask;
            pend_valid_d = 1'b0;
        end else if (boundary && pend_valid_q) begin
            disp_dig_d   = pend_dig_q;
            disp_dp_d    = pend_dp_q;
            pend_valid_d = 1'b0;
        end else if (load) begin
            pend_dig_d   = load_dig;
            pend_dp_d    = dp_mask;
            pend_valid_d = 1'b1;
        end

        sel_code = disp_dig_d[idx_d];
    end

    ssd_decoder u_decoder (
        .code_i (sel_code),
        .seg_o  (dec_seg)
    );

    always_comb begin
`ifdef SSD_LEADING_ZERO_BLANK_EN
        blank[3] = (disp_dig_d[3] == 4'd0);
        blank[2] = blank[3] && (disp_dig_d[2] == 4'd0);
        blank[1] = blank[2] && (disp_dig_d[1] == 4'd0);
        blank[0] = 1'b0;
`else
        blank = 4'b0000;
`endif
    end

    always_comb begin
        ctl_d = ctl_q;
        seg_d = seg_q;
        if (tick) begin
            ctl_d = ~(4'b0001 << idx_d);
            seg_d = {blank[idx_d] ? SEG_BLANK[SEG_A_BIT:SEG_G_BIT] : dec_seg,
                     ~disp_dp_d[idx_d]};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt_q    <= '0;
            idx_q        <= IDX_RESET;
            pend_dig_q   <= '0;
            pend_dp_q    <= '0;
            pend_valid_q <= 1'b0;
            disp_dig_q   <= '0;
            disp_dp_q    <= '0;
            ctl_q        <= 4'b1111;
            seg_q        <= SEG_BLANK;
        end else begin
            div_cnt_q    <= div_cnt_d;
            idx_q        <= idx_d;
            pend_dig_q   <= pend_dig_d;
            pend_dp_q    <= pend_dp_d;
            pend_valid_q <= pend_valid_d;
            disp_dig_q   <= disp_dig_d;
            disp_dp_q    <= disp_dp_d;
            ctl_q        <= ctl_d;
            seg_q        <= seg_d;
        end
    end

    assign ssd_ctl    = ctl_q;
    assign ssd_seg    = seg_q;
    // Marks the cycle whose closing edge starts a new frame; a load here commits directly.
    assign frame_done = boundary && !rst;

endmodule

// File: tb/tb_ssd_scan_driver.sv
// Scoreboard bench for ssd_scan_driver: the model reasons in slots and frames, not registers.
module tb_ssd_scan_driver;

    localparam int unsigned DIV = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] d3, d2, d1, d0;
    logic       load;
    logic [3:0] dp_mask;
    logic [3:0] ssd_ctl;
    logic [7:0] ssd_seg;
    logic       frame_done;

    always #5 clk = ~clk;

    ssd_scan_driver #(
        .REFRESH_DIV (DIV)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .d3         (d3),
        .d2         (d2),
        .d1         (d1),
        .d0         (d0),
        .load       (load),
        .dp_mask    (dp_mask),
        .ssd_ctl    (ssd_ctl),
        .ssd_seg    (ssd_seg),
        .frame_done (frame_done)
    );

    typedef struct {
        int         t;
        logic [3:0] ctl;
        logic [7:0] seg;
    } exp_t;

    exp_t q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   t       = 0;     // posedges since reset release

    logic [3:0] latest[4];
    logic [3:0] latest_dp;
    logic [3:0] shown[4];
    logic [3:0] shown_dp;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0d)", name, act, exp, t);
        end
    endtask

    function automatic logic [7:0] glyph(input logic [3:0] c);
        case (c)
            4'd0: return 8'b0000_0011;
            4'd1: return 8'b1001_1111;
            4'd2: return 8'b0010_0101;
            4'd3: return 8'b0000_1101;
            4'd4: return 8'b1001_1001;
            4'd5: return 8'b0100_1001;
            4'd6: return 8'b0100_0001;
            4'd7: return 8'b0001_1111;
            4'd8: return 8'b0000_0001;
            4'd9: return 8'b0000_1001;
            default: return 8'b1111_1101;
        endcase
    endfunction

    function automatic logic [7:0] expect_seg(input int dig);
        logic [7:0] g;
        bit         blank;
        g     = glyph(shown[dig]);
        blank = 1'b0;
`ifdef SSD_LEADING_ZERO_BLANK_EN
        if (dig > 0) begin
            blank = 1'b1;
            for (int k = dig; k < 4; k++) if (shown[k] != 4'd0) blank = 1'b0;
        end
`endif
        if (blank) g = 8'hFF;
        g[0] = ~shown_dp[dig];
        return g;
    endfunction

    task automatic model_clear();
        for (int k = 0; k < 4; k++) begin
            latest[k] = 4'd0;
            shown[k]  = 4'd0;
        end
        latest_dp = 4'd0;
        shown_dp  = 4'd0;
    endtask

    // Called at a negedge; drives one cycle and advances the model past the next posedge.
    task automatic step(input bit ld, input logic [3:0] a3, input logic [3:0] a2,
                        input logic [3:0] a1, input logic [3:0] a0, input logic [3:0] dpm);
        exp_t e;
        int   dig;
        load = ld; d3 = a3; d2 = a2; d1 = a1; d0 = a0; dp_mask = dpm;
        #1;
        check("frame_done", {31'd0, frame_done}, {31'd0, ((t + 1) % 16) == 4});
        @(posedge clk);
        t++;
        if (ld) begin
            latest[3] = a3; latest[2] = a2; latest[1] = a1; latest[0] = a0;
            latest_dp = dpm;
        end
        if (t % DIV == 0) begin
            dig = ((t / DIV) - 1) % 4;
            // Each frame shows whatever was loaded last, up to and including its boundary cycle.
            if (dig == 0) begin
                shown    = latest;
                shown_dp = latest_dp;
            end
            e.t   = t;
            e.ctl = ~(4'b0001 << dig);
            e.seg = expect_seg(dig);
            q.push_back(e);
        end
        @(negedge clk);
        load = 1'b0;
    endtask

    task automatic idle_to(input int edge_no);
        while (t < edge_no - 1) step(1'b0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0);
    endtask

    task automatic do_reset(input int cycles);
        rst  = 1'b1;
        load = 1'b1;
        d3 = 4'd1; d2 = 4'd1; d1 = 4'd1; d0 = 4'd1; dp_mask = 4'hF;
        repeat (cycles) @(posedge clk);
        @(negedge clk);
        rst  = 1'b0;
        load = 1'b0;
        t    = 0;
        model_clear();
        check("queue empty at reset", q.size(), 0);
        q.delete();
        #1;
        check("reset ssd_ctl", {28'd0, ssd_ctl}, 32'hF);
        check("reset ssd_seg", {24'd0, ssd_seg}, 32'hFF);
        check("reset frame_done", {31'd0, frame_done}, 0);
    endtask

    // Monitor: every ssd_ctl change outside reset is one output slot to score.
    initial begin
        logic [3:0] prev;
        logic       r;
        exp_t       e;
        prev = 4'bxxxx;
        forever begin
            @(posedge clk);
            r = rst;
            #1;
            if (!r && ssd_ctl !== prev) begin
                if (q.size() == 0) begin
                    check("unexpected output change", {28'd0, ssd_ctl}, {28'd0, prev});
                end else begin
                    e = q.pop_front();
                    check("slot timing", t, e.t);
                    check("ssd_ctl", {28'd0, ssd_ctl}, {28'd0, e.ctl});
                    check("ssd_seg", {24'd0, ssd_seg}, {24'd0, e.seg});
                end
            end
            prev = ssd_ctl;
        end
    end

    initial begin
        rst = 1'b1; load = 1'b0;
        d3 = 4'd0; d2 = 4'd0; d1 = 4'd0; d0 = 4'd0; dp_mask = 4'd0;
        model_clear();
        @(negedge clk);
        do_reset(3);

        // Reset and first frames, then directed loads.
        idle_to(18);
        step(1'b1, 4'd2, 4'd0, 4'd2, 4'd4, 4'd0);
        idle_to(22);
        step(1'b1, 4'd1, 4'd1, 4'd1, 4'd1, 4'd0);
        idle_to(25);
        step(1'b1, 4'd9, 4'd9, 4'd9, 4'd9, 4'd0);
        idle_to(52);
        step(1'b1, 4'd0, 4'd0, 4'd0, 4'd7, 4'd0);
        idle_to(60);
        step(1'b1, 4'd3, 4'd8, 4'hC, 4'd6, 4'b0010);
        idle_to(70);
        step(1'b1, 4'd0, 4'd0, 4'd5, 4'd0, 4'b1000);
        idle_to(102);
        step(1'b1, 4'd0, 4'd0, 4'd0, 4'd0, 4'b0101);
        idle_to(150);

        // Reset mid-frame with a load pending.
        step(1'b1, 4'd8, 4'd8, 4'd8, 4'd8, 4'hF);
        do_reset(2);
        idle_to(40);

        // Randomized loads, including non-BCD codes and occasional boundary hits.
        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(0, 7) == 0)
                step(1'b1, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                     4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                     4'($urandom_range(0, 15)));
            else if ($urandom_range(0, 9) == 0)
                step(1'b1, 4'd0, 4'd0, 4'($urandom_range(0, 1)), 4'($urandom_range(0, 9)),
                     4'd0);
            else
                step(1'b0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0);
            if (i == 1000) do_reset(1 + int'($urandom_range(0, 3)));
        end

        step(1'b0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0);
        check("scoreboard drained", q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/ssd_scan_driver.md
# ssd_scan_driver

Time-multiplexed driver for a 4-digit, common-anode seven-segment display. It consumes the BCD digit pairs produced by the counter stages, with the year tens/ones digits on the left pair, and scans one digit per refresh slot. New digit values are double-buffered and committed only at a frame boundary, so the display never shows a torn update.

## Interface
Parameters:
- REFRESH_DIV, 100000: clock cycles per digit slot; legal range ≥ 2. The divider counter width is $clog2(REFRESH_DIV).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- d3  in  4  leftmost digit, BCD (year tens)
- d2  in  4  digit 2, BCD (year ones)
- d1  in  4  digit 1, BCD
- d0  in  4  rightmost digit, BCD
- load  in  1  one-cycle strobe that captures d3..d0 and dp_mask into the pending buffer
- dp_mask  in  4  decimal-point enable per digit; bit i belongs to digit i
- ssd_ctl  out  4  digit enables, active-low; bit i drives digit i
- ssd_seg  out  8  segments, active-low, {a,b,c,d,e,f,g,dp}
- frame_done  out  1  one-cycle pulse when a new frame starts

## Operation
- **Divider:** `div_cnt` counts 0..REFRESH_DIV-1 and wraps. `tick` is asserted when `div_cnt == REFRESH_DIV-1`.
- **Digit index:** `idx` is 2 bits and resets to 3. On each tick it advances 3→0→1→2→3.
- **Frame boundary:** a tick on which `idx` goes 3→0. frame_done pulses on exactly those cycles, including the first tick after reset.
- **Pending buffer:** a load cycle copies d3..d0 and dp_mask into `pend_*` and sets `pend_valid`. A later load before the boundary overwrites the buffer; the last load wins.
- **Commit:** at a frame boundary with `pend_valid=1`, the pending data is copied into `disp_*` and `pend_valid` is cleared.
- **Load on the boundary cycle:** the input data is committed directly to `disp_*`, bypassing the pending buffer. `pend_valid` ends at 0.
- **Output registers:**
  - Outputs are registered and updated only on tick.
  - `ssd_ctl` is all ones except bit `idx_next`, which is 0.
  - `ssd_seg` is `decode(disp_next[idx_next])`, with dp taken from `~dp_mask_next[idx_next]`.
  - `*_next` means the value after any commit on that same edge.
- **Decode:**
  - Codes 0–9 map to standard glyphs; for example 0 → 8'b0000_0011 and 8 → 8'b0000_0001, with the dp bit shown off.
  - Codes 10–15 show a dash, g only: 8'b1111_1101 with dp off.
- **Between ticks:** outputs hold their values.

## Timing
- **Reset values:**
  - Outputs: `ssd_ctl=4'b1111`, `ssd_seg=8'hFF`, `frame_done=0`.
  - Internal state: `div_cnt=0`, `idx=3`, `disp_*=0`, `dp_mask` register 0, `pend_valid=0`.
- **First tick:** occurs REFRESH_DIV cycles after rst is released. It selects digit 0, `ssd_ctl=4'b1110`, and pulses frame_done.
- **Load-to-visible latency:** at most 4·REFRESH_DIV cycles, at least 1 cycle when the load coincides with a boundary. A digit becomes visible only in its own slot.
- **Reset mid-frame:** all state returns to reset values on the next edge, and pending data is discarded.
- **rst and load in the same cycle:** rst wins.

## Configuration
- `SSD_LEADING_ZERO_BLANK_EN` defined:
  - d3, d2, d1 each show blank (8'hFF apart from dp) when the digit is 0 and every digit to its left is 0.
  - d0 is never blanked.
  - dp follows dp_mask regardless of blanking.
- Undefined: every digit is decoded normally, and zeros display as "0".

## Structure
- **Package `ssd_pkg`:**
  - Active-low glyph constants SEG_0..SEG_9, SEG_DASH and SEG_BLANK.
  - Segment bit-order localparams.
  - Function `bcd_to_seg`.
- **Sub-module `ssd_decoder`:** combinational 4-bit code to 7-bit segments, one instance fed by the selected digit.
- **Top module:** divider, index counter, pending and display buffers, blanking logic and output registers.

## Test plan
All scenarios run with REFRESH_DIV=4.
- **Reset and first frame:** reset, then 4 cycles → `ssd_ctl` goes 1111→1110 and frame_done pulses once. Afterwards ctl steps 1101, 1011, 0111 every 4 cycles.
- **Load then commit:** load d3..d0=2,0,2,4 mid-frame → display unchanged until the next frame_done. After it, slots show SEG_4, SEG_2, SEG_0, SEG_2 for digits 0..3.
- **Double load:** load 1,1,1,1 then load 9,9,9,9 in the same frame → only 9s appear. No 1 is ever driven.
- **Boundary coincidence:** load 0,0,0,7 on the frame_done cycle → digit 0 shows SEG_7 in that same slot.
- **Invalid BCD and dp:** d1=4'hC with dp_mask=4'b0010 → the digit-1 slot shows 8'b1111_1100, a dash with dp on.
- **Leading-zero blanking (macro on):** digits 0,0,5,0 → d3 and d2 show 8'hFF, d1=SEG_5, d0=SEG_0. With the macro off, SEG_0 is shown on d3 and d2.
